// File: rtl/bfly_sdf_stage.sv
// Radix-2 single-delay-feedback butterfly: streams a+b while the enable window is open, then replays the stored a-b.
// Optional BFLY_SCALE_EN: halve every result (arithmetic shift right by 1) for per-stage 1/2 scaling.
module bfly_sdf_stage #(
    parameter int DATA_WIDTH = 9,
    parameter int SIZE       = 16,
    parameter int IN_SIZE    = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    bfly_en,
    input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0]      a_i,
    input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0]      a_q,
    input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0]      b_i,
    input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0]      b_q,
    output logic [IN_SIZE-1:0][DATA_WIDTH:0]        dout_i,
    output logic [IN_SIZE-1:0][DATA_WIDTH:0]        dout_q,
    output logic                                    dout_valid,
    output logic                                    dout_is_diff,
    output logic                                    ovr
);
    localparam int OW = DATA_WIDTH + 1;
    localparam int CW = $clog2(SIZE + 1);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int MW = 2 * IN_SIZE * OW;

    typedef enum logic [1:0] {IDLE, SUM, DIFF} state_t;

    state_t                        state_q;
    logic [CW-1:0]                 cnt_q;
    logic [IN_SIZE-1:0][OW-1:0]    dout_i_q, dout_q_q;
    logic                          dout_valid_q, dout_is_diff_q, ovr_q;

    logic [IN_SIZE-1:0][OW-1:0]    sum_i_d, sum_q_d, dif_i_d, dif_q_d;
    logic [MW-1:0]                 diff_mem [SIZE];
    logic                          accept;
    logic [AW-1:0]                 mem_addr;
    logic                          last_cnt;

    function automatic logic [OW-1:0] scale(input logic signed [OW-1:0] x);
`ifdef BFLY_SCALE_EN
        return x >>> 1;
`else
        return x;
`endif
    endfunction

    // Operands are widened by one bit so add/sub is exact.
    for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_lane
        logic signed [OW-1:0] ai_x, aq_x, bi_x, bq_x;
        assign ai_x = {a_i[gi][DATA_WIDTH-1], a_i[gi]};
        assign aq_x = {a_q[gi][DATA_WIDTH-1], a_q[gi]};
        assign bi_x = {b_i[gi][DATA_WIDTH-1], b_i[gi]};
        assign bq_x = {b_q[gi][DATA_WIDTH-1], b_q[gi]};
        assign sum_i_d[gi] = scale(ai_x + bi_x);
        assign sum_q_d[gi] = scale(aq_x + bq_x);
        assign dif_i_d[gi] = scale(ai_x - bi_x);
        assign dif_q_d[gi] = scale(aq_x - bq_x);
    end

    assign accept   = bfly_en && (state_q != DIFF);
    assign mem_addr = cnt_q[AW-1:0];
    assign last_cnt = (cnt_q == CW'(SIZE - 1));

    // Difference buffer: write index = accepted pair number, read index = diff slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            diff_mem[mem_addr] <= {dif_q_d, dif_i_d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dout_i_q       <= '0;
            dout_q_q       <= '0;
            dout_valid_q   <= 1'b0;
            dout_is_diff_q <= 1'b0;
            ovr_q          <= 1'b0;
        end else if (state_q == DIFF) begin
            {dout_q_q, dout_i_q} <= diff_mem[mem_addr];
            dout_valid_q         <= 1'b1;
            dout_is_diff_q       <= 1'b1;
            if (bfly_en) begin
                ovr_q <= 1'b1;
            end
            if (last_cnt) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (accept) begin
            dout_i_q       <= sum_i_d;
            dout_q_q       <= sum_q_d;
            dout_valid_q   <= 1'b1;
            dout_is_diff_q <= 1'b0;
            if (last_cnt) begin
                state_q <= DIFF;
                cnt_q   <= '0;
            end else begin
                state_q <= SUM;
                cnt_q   <= cnt_q + 1'b1;
            end
        end else begin
            // Idle or stalled mid-block: hold state, no output this cycle.
            dout_valid_q <= 1'b0;
        end
    end

    assign dout_i       = dout_i_q;
    assign dout_q       = dout_q_q;
    assign dout_valid   = dout_valid_q;
    assign dout_is_diff = dout_is_diff_q;
    assign ovr          = ovr_q;
endmodule

// File: doc/bfly_sdf_stage.md
# bfly_sdf_stage

Radix-2 single-delay-feedback butterfly that consumes the delayed lanes and the enable window produced by the FIFO delay line directly upstream, together with the live input lanes. During each 16-cycle enable window it emits the lane-wise sums a+b, storing the differences a−b. It then streams the stored differences in the following 16 cycles, giving a continuous 32-cycle output block. Twiddle multiplication is done downstream; this block performs add/subtract and reordering only.

## Interface
- DATA_WIDTH, 9, input sample width (signed, per I/Q component)
- SIZE, 16, half-block length: sum outputs per block, and depth of the difference buffer
- IN_SIZE, 16, parallel lanes per cycle
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- bfly_en  in  1  upstream enable window; a/b lanes are valid while high
- a_i, a_q  in  DATA_WIDTH x IN_SIZE  delayed (FIFO front) lanes, signed
- b_i, b_q  in  DATA_WIDTH x IN_SIZE  current input lanes, signed
- dout_i, dout_q  out  (DATA_WIDTH+1) x IN_SIZE  butterfly result lanes, signed
- dout_valid  out  1  dout lanes valid this cycle
- dout_is_diff  out  1  1 = difference half, 0 = sum half (meaningful only when dout_valid)
- ovr  out  1  sticky overrun flag

## Operation
- FSM states: IDLE, SUM, DIFF. Internal counter cnt, width $clog2(SIZE+1).
- IDLE: when bfly_en=1, accept the first pair and go to SUM with cnt=1.
- SUM: each cycle with bfly_en=1, accept one pair and increment cnt. When bfly_en=0, stall: no accept, no output, state held. After the SIZE-th accepted pair, go to DIFF with cnt=0.
- Accepted pair k (0..SIZE-1): register sum a+b to dout; write diff a−b to buffer entry k. Compute per lane and per I/Q component.
- DIFF: emit buffer entry cnt each cycle unconditionally, cnt 0..SIZE-1, then return to IDLE. bfly_en is ignored here; if bfly_en=1 in any DIFF cycle, set ovr=1. That data is dropped.
- ovr is sticky and clears only on rst.
- Arithmetic: sign-extend both operands to DATA_WIDTH+1 before add/sub. Exact, no overflow, no rounding (see Configuration).
- Reset (asynchronous, any state): state=IDLE, cnt=0, dout_i/dout_q=0, dout_valid=0, dout_is_diff=0, ovr=0. The buffer contents need not be cleared. A partial block in progress at reset is discarded.

## Timing
- Sum latency 1 cycle: a pair accepted at cycle t appears on dout at t+1 with dout_valid=1 and dout_is_diff=0.
- Last pair accepted at cycle T: sum at T+1; diff entries 0..SIZE-1 at T+2..T+SIZE+1 with dout_valid=1 and dout_is_diff=1.
- With bfly_en high for SIZE consecutive cycles, dout_valid is high for 2*SIZE consecutive cycles.
- FSM state is IDLE at cycle T+SIZE+1, the last diff cycle. bfly_en=1 in that cycle starts a new block; its sum appears at T+SIZE+2, so output stays continuous.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- BFLY_SCALE_EN defined: every sum and diff is arithmetically shifted right by 1 (floor) after the (DATA_WIDTH+1)-bit add/sub. The result is then sign-extended back to DATA_WIDTH+1. This gives 1/2 scaling per stage.
- BFLY_SCALE_EN undefined: full-precision results, no shift.
- Timing, FSM and flags are identical in both builds.

## Test plan
- Reset mid-DIFF: pulse rst at diff entry 5 -> outputs zero immediately and asynchronously; dout_valid=0; next enable starts a fresh SUM block with ovr=0.
- Ramp: a_i[j]=j, b_i[j]=2j, q=0, bfly_en high 16 cycles -> 16 cycles of dout_i[j]=3j, then 16 cycles of dout_i[j]=−j with dout_is_diff=1; dout_valid high 32 consecutive cycles.
- Extremes: a=255, b=255 -> sum 510; a=−256, b=255 -> diff −511; with BFLY_SCALE_EN, 255 and −256 respectively.
- Stall: bfly_en low for 3 cycles after pair 7 -> dout_valid low for exactly those 3 cycles; remaining sums and all 16 diffs are correct and in order.
- Overrun: bfly_en high during DIFF cycle 4 -> ovr=1 and stays 1; the diff stream is unaffected; that data is not output.
- Back-to-back: a second 16-cycle window starts in the last diff cycle -> no gap in dout_valid; second block correct; ovr stays 0.
